piece_controller: RTL and testbench
===================================

# piece_controller

Parametrised active-tetromino controller for the Tetris core, sitting between the keyboard input-delay stage and the board/line-clear logic. It spawns a piece from a supplied shape code, applies gravity, moves and rotates on single-cycle action pulses, and checks every candidate position against the board edges and the occupancy map. Grounded pieces get a lock delay, after which the four final cells are handed to the board. A blocked spawn sets a sticky game-over.

## Interface
Parameters:
- BOARD_W, 10, board columns; XW = $clog2(BOARD_W)
- BOARD_H, 20, board rows, row 0 at bottom; YW = $clog2(BOARD_H)
- DROP_PERIOD, 30, frame ticks per gravity step (≥1)
- LOCK_DELAY, 15, frame ticks a grounded piece waits before locking (≥1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- frame_tick  in  1  one-cycle pulse per video frame
- spawn  in  1  spawn request pulse
- shape_in  in  3  0=I 1=O 2=T 3=J 4=L 5=S 6=Z; 7 is invalid
- move_left, move_right, rotate_cw, soft_drop  in  1 each  action pulses
- board_occ  in  BOARD_H*BOARD_W  occupancy; bit index y*BOARD_W+x
- cells_x  out  4*XW  cell k in bits [k*XW +: XW]
- cells_y  out  4*YW  cell k in bits [k*YW +: YW]
- shape  out  3  current shape
- orientation  out  2  0..3, clockwise count
- active  out  1  a piece is in FALLING or LOCKING
- lock_valid  out  1  one-cycle pulse; cells_x/cells_y hold the locked cells
- game_over  out  1  sticky until reset

## Operation
- The piece is stored as a pivot (px, py), a shape and an orientation. Each cell = pivot + offset.
- Orientation-0 offsets (dx,dy):
  - I: (-1,0)(0,0)(1,0)(2,0)
  - O: (0,0)(1,0)(0,1)(1,1)
  - T: (-1,0)(0,0)(1,0)(0,1)
  - J: (-1,1)(-1,0)(0,0)(1,0)
  - L: (-1,0)(0,0)(1,0)(1,1)
  - S: (-1,0)(0,0)(0,1)(1,1)
  - Z: (-1,1)(0,1)(0,0)(1,0)
- Each clockwise step maps (dx,dy) to (dy,-dx). O ignores rotate_cw, and its orientation stays 0.
- Candidate legality: all 4 cells satisfy 0≤x<BOARD_W and 0≤y<BOARD_H, and their board_occ bits are 0. Signed arithmetic is at least 1 bit wider than XW/YW so no wrap-around occurs.
- States: IDLE, FALLING, LOCKING, OVER.
- IDLE:
  - spawn with shape_in≠7: pivot = (BOARD_W/2-1, BOARD_H-2), orientation 0.
  - If legal, go to FALLING. If illegal, go to OVER and set game_over.
  - shape_in=7 is ignored. spawn outside IDLE is ignored.
- FALLING/LOCKING, at most one action per cycle. Priority: gravity > rotate_cw > move_left > move_right > soft_drop.
- Gravity:
  - frame_tick in FALLING with drop_cnt = DROP_PERIOD-1 attempts py-1. Otherwise frame_tick increments drop_cnt.
  - drop_cnt clears on spawn and on any successful down step.
- Down step (gravity or soft_drop): if illegal, the position is held, lock_cnt is cleared and the state goes to LOCKING.
- LOCKING:
  - Gravity is suspended. frame_tick increments lock_cnt.
  - Any successful move or rotate returns to FALLING, keeping drop_cnt.
  - soft_drop while in LOCKING locks immediately.
  - When lock_cnt reaches LOCK_DELAY, pulse lock_valid and go to IDLE.
- Illegal candidates are discarded silently and leave state and counters unchanged.
- Outputs when not active (IDLE, OVER, reset): cells all-ones (off-board marker), shape 7, orientation 0.
- OVER is left only by reset.

## Timing
- Action sampled at edge N; registered outputs reflect the new position after edge N. Latency is 1 cycle.
- board_occ is sampled in the same cycle as the action.
- lock_valid is high for exactly one cycle. During that cycle cells and shape still show the locked piece; they go to the inactive values the next cycle.
- spawn is accepted in the cycle after lock_valid at the earliest.
- Reset mid-operation: the state returns to IDLE immediately (asynchronous), and all counters, outputs and game_over go to their inactive/0 values.

## Configuration
- PIECE_WALL_KICK_EN defined: if a rotation candidate is illegal, try pivot x-1, then x+1, in the same cycle. The first legal candidate is taken.
- PIECE_WALL_KICK_EN undefined: an illegal rotation is simply rejected.

## Test plan
- Empty board, spawn T: cells (3,18)(4,18)(5,18)(4,19), active=1. After 30 frame_ticks: y=17,17,17,18.
- Empty board I piece, move_left ×5: pivot x stops at 1 (cell x=0). The 4th and 5th pulses are rejected.
- T on an empty floor:
  - Descends to py=0, then enters LOCKING.
  - 15 frame_ticks later: one lock_valid pulse with cells (3,0)(4,0)(5,0)(4,1), then outputs all-ones.
- I at orientation 1 against the right wall, rotate_cw:
  - With PIECE_WALL_KICK_EN: rotates with pivot shifted left.
  - Without it: orientation is unchanged.
- Cell (4,18) occupied, spawn O: game_over=1, active=0. A further spawn is ignored until reset.
- Gravity frame_tick and move_left in the same cycle: only the down step is applied.

Source files
------------

// File: rtl/piece_controller.sv
// Active-tetromino controller: spawn, gravity, move/rotate with legality checks, lock delay, game-over.
// Optional feature: define PIECE_WALL_KICK_EN to retry illegal rotations at pivot x-1, then x+1.
module piece_controller #(
  parameter int BOARD_W     = 10,
  parameter int BOARD_H     = 20,
  parameter int DROP_PERIOD = 30,
  parameter int LOCK_DELAY  = 15,
  localparam int XW = $clog2(BOARD_W),
  localparam int YW = $clog2(BOARD_H)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_tick,
  input  logic                   spawn,
  input  logic [2:0]             shape_in,
  input  logic                   move_left,
  input  logic                   move_right,
  input  logic                   rotate_cw,
  input  logic                   soft_drop,
  input  logic [BOARD_H*BOARD_W-1:0] board_occ,
  output logic [4*XW-1:0]        cells_x,
  output logic [4*YW-1:0]        cells_y,
  output logic [2:0]             shape,
  output logic [1:0]             orientation,
  output logic                   active,
  output logic                   lock_valid,
  output logic                   game_over
);

  localparam int NCELL   = BOARD_H * BOARD_W;
  localparam int IW      = $clog2(NCELL);
  localparam int DW      = $clog2(DROP_PERIOD + 1);
  localparam int LW      = $clog2(LOCK_DELAY + 1);
  localparam int SPAWN_X = BOARD_W / 2 - 1;
  localparam int SPAWN_Y = BOARD_H - 2;

  typedef enum logic [1:0] {IDLE, FALLING, LOCKING, OVER} state_t;

  state_t          state, state_n;
  logic [XW-1:0]   px, px_n;
  logic [YW-1:0]   py, py_n;
  logic [1:0]      rot, rot_n, rot_c;
  logic [2:0]      shp, shp_n;
  logic [DW-1:0]   drop_cnt, drop_n;
  logic [LW-1:0]   lock_cnt, lock_n;
  logic            over_n;
  logic            grav, down_req, down_ok, lock_due;

  // Every shape contains offset (0,0), so the pivot itself is always an on-board cell.
  function automatic void cell_off(input logic [2:0] s, input logic [1:0] r,
                                   input int unsigned k, output int dx, output int dy);
    int t;
    dx = 0;
    dy = 0;
    case (s)
      3'd0: begin dx = int'(k) - 1; dy = 0; end
      3'd1: begin dx = int'(k % 2); dy = int'(k / 2); end
      3'd2: if (k == 3) begin dx = 0;  dy = 1; end else begin dx = int'(k) - 1; dy = 0; end
      3'd3: if (k == 0) begin dx = -1; dy = 1; end else begin dx = int'(k) - 2; dy = 0; end
      3'd4: if (k == 3) begin dx = 1;  dy = 1; end else begin dx = int'(k) - 1; dy = 0; end
      3'd5: if (k < 2) begin dx = int'(k) - 1; dy = 0; end else begin dx = int'(k) - 2; dy = 1; end
      3'd6: if (k < 2) begin dx = int'(k) - 1; dy = 1; end else begin dx = int'(k) - 2; dy = 0; end
      default: begin dx = 0; dy = 0; end
    endcase
    for (int unsigned i = 0; i < 3; i++) begin
      if (i < 32'(r)) begin
        t  = dx;
        dx = dy;
        dy = -t;
      end
    end
  endfunction

  function automatic logic legal(input int cx, input int cy, input logic [2:0] s,
                                 input logic [1:0] r, input logic [NCELL-1:0] occ);
    int dx, dy, x, y;
    logic ok;
    logic [IW-1:0] idx;
    ok = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      cell_off(s, r, k, dx, dy);
      x = cx + dx;
      y = cy + dy;
      if (x < 0 || x >= BOARD_W || y < 0 || y >= BOARD_H) begin
        ok = 1'b0;
      end else begin
        idx = IW'(y * BOARD_W + x);
        if (occ[idx]) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  assign lock_due = (state == LOCKING) && (lock_cnt == LW'(LOCK_DELAY));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      px        <= '0;
      py        <= '0;
      rot       <= '0;
      shp       <= '0;
      drop_cnt  <= '0;
      lock_cnt  <= '0;
      game_over <= 1'b0;
    end else begin
      state     <= state_n;
      px        <= px_n;
      py        <= py_n;
      rot       <= rot_n;
      shp       <= shp_n;
      drop_cnt  <= drop_n;
      lock_cnt  <= lock_n;
      game_over <= over_n;
    end
  end

  always_comb begin
    state_n  = state;
    px_n     = px;
    py_n     = py;
    rot_n    = rot;
    shp_n    = shp;
    drop_n   = drop_cnt;
    lock_n   = lock_cnt;
    over_n   = game_over;
    down_req = 1'b0;
    rot_c    = rot + 2'd1;
    grav     = (state == FALLING) && frame_tick && (drop_cnt == DW'(DROP_PERIOD - 1));
    down_ok  = legal(int'(px), int'(py) - 1, shp, rot, board_occ);
    case (state)
      IDLE: begin
        if (spawn && shape_in != 3'd7) begin
          px_n   = XW'(SPAWN_X);
          py_n   = YW'(SPAWN_Y);
          rot_n  = '0;
          shp_n  = shape_in;
          drop_n = '0;
          lock_n = '0;
          if (legal(SPAWN_X, SPAWN_Y, shape_in, 2'd0, board_occ)) begin
            state_n = FALLING;
          end else begin
            state_n = OVER;
            over_n  = 1'b1;
          end
        end
      end
      FALLING, LOCKING: begin
        if (state == FALLING && frame_tick && !grav) drop_n = drop_cnt + DW'(1);
        if (state == LOCKING && frame_tick && lock_cnt < LW'(LOCK_DELAY)) lock_n = lock_cnt + LW'(1);
        // Only the highest-priority pulse present is considered, even if its candidate is illegal.
        if (lock_due) begin
          state_n = IDLE;
        end else if (grav) begin
          down_req = 1'b1;
        end else if (rotate_cw && shp != 3'd1) begin
          if (legal(int'(px), int'(py), shp, rot_c, board_occ)) begin
            rot_n   = rot_c;
            state_n = FALLING;
          end
`ifdef PIECE_WALL_KICK_EN
          else if (legal(int'(px) - 1, int'(py), shp, rot_c, board_occ)) begin
            rot_n   = rot_c;
            px_n    = px - XW'(1);
            state_n = FALLING;
          end else if (legal(int'(px) + 1, int'(py), shp, rot_c, board_occ)) begin
            rot_n   = rot_c;
            px_n    = px + XW'(1);
            state_n = FALLING;
          end
`endif
        end else if (move_left) begin
          if (legal(int'(px) - 1, int'(py), shp, rot, board_occ)) begin
            px_n    = px - XW'(1);
            state_n = FALLING;
          end
        end else if (move_right) begin
          if (legal(int'(px) + 1, int'(py), shp, rot, board_occ)) begin
            px_n    = px + XW'(1);
            state_n = FALLING;
          end
        end else if (soft_drop) begin
          if (state == LOCKING) lock_n = LW'(LOCK_DELAY);
          else down_req = 1'b1;
        end
        if (down_req) begin
          if (down_ok) begin
            py_n   = py - YW'(1);
            drop_n = '0;
          end else begin
            lock_n  = '0;
            state_n = LOCKING;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    int dx, dy;
    dx          = 0;
    dy          = 0;
    active      = (state == FALLING) || (state == LOCKING);
    lock_valid  = lock_due;
    cells_x     = '1;
    cells_y     = '1;
    shape       = 3'd7;
    orientation = '0;
    if (active) begin
      shape       = shp;
      orientation = rot;
      for (int unsigned k = 0; k < 4; k++) begin
        cell_off(shp, rot, k, dx, dy);
        cells_x[k*XW +: XW] = XW'(int'(px) + dx);
        cells_y[k*YW +: YW] = YW'(int'(py) + dy);
      end
    end
  end

endmodule

// File: tb/tb_piece_controller.sv
// Directed self-checking bench for piece_controller (10x20 board, default timing parameters).
module tb_piece_controller;

  logic         clk;
  logic         reset;
  logic         frame_tick, spawn, move_left, move_right, rotate_cw, soft_drop;
  logic [2:0]   shape_in;
  logic [199:0] board_occ;
  logic [15:0]  cells_x;
  logic [19:0]  cells_y;
  logic [2:0]   shape;
  logic [1:0]   orientation;
  logic         active, lock_valid, game_over;

  int checks = 0;
  int errors = 0;

  piece_controller #(
    .BOARD_W(10),
    .BOARD_H(20),
    .DROP_PERIOD(30),
    .LOCK_DELAY(15)
  ) dut (
    .clk(clk),
    .reset(reset),
    .frame_tick(frame_tick),
    .spawn(spawn),
    .shape_in(shape_in),
    .move_left(move_left),
    .move_right(move_right),
    .rotate_cw(rotate_cw),
    .soft_drop(soft_drop),
    .board_occ(board_occ),
    .cells_x(cells_x),
    .cells_y(cells_y),
    .shape(shape),
    .orientation(orientation),
    .active(active),
    .lock_valid(lock_valid),
    .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    spawn      = 1'b0;
    frame_tick = 1'b0;
    move_left  = 1'b0;
    move_right = 1'b0;
    rotate_cw  = 1'b0;
    soft_drop  = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cells(input string tag, input int x0, input int y0, input int x1, input int y1,
                           input int x2, input int y2, input int x3, input int y3);
    logic [15:0] ex;
    logic [19:0] ey;
    ex = {4'(x3), 4'(x2), 4'(x1), 4'(x0)};
    ey = {5'(y3), 5'(y2), 5'(y1), 5'(y0)};
    chk({tag, "_x"}, 32'(cells_x), 32'(ex));
    chk({tag, "_y"}, 32'(cells_y), 32'(ey));
  endtask

  initial begin
    reset = 1'b1;
    frame_tick = 1'b0; spawn = 1'b0; move_left = 1'b0; move_right = 1'b0;
    rotate_cw = 1'b0; soft_drop = 1'b0; shape_in = 3'd0; board_occ = '0;
    #12;
    chk("rst_active", 32'(active), 0);
    chk("rst_lock_valid", 32'(lock_valid), 0);
    chk("rst_game_over", 32'(game_over), 0);
    chk("rst_shape", 32'(shape), 7);
    chk("rst_cells_x", 32'(cells_x), 32'h0000ffff);
    chk("rst_cells_y", 32'(cells_y), 32'h000fffff);
    reset = 1'b0;
    tick();

    // T spawn and gravity
    shape_in = 3'd2; spawn = 1'b1; tick();
    chk_cells("spawn_t", 3, 18, 4, 18, 5, 18, 4, 19);
    chk("spawn_t_active", 32'(active), 1);
    chk("spawn_t_shape", 32'(shape), 2);
    chk("spawn_t_orient", 32'(orientation), 0);
    shape_in = 3'd0; spawn = 1'b1; tick();
    chk("spawn_ignored_shape", 32'(shape), 2);
    repeat (29) begin frame_tick = 1'b1; tick(); end
    chk_cells("grav_29", 3, 18, 4, 18, 5, 18, 4, 19);
    frame_tick = 1'b1; tick();
    chk_cells("grav_30", 3, 17, 4, 17, 5, 17, 4, 18);
    repeat (29) begin frame_tick = 1'b1; tick(); end
    frame_tick = 1'b1; move_left = 1'b1; tick();
    chk_cells("grav_over_left", 3, 16, 4, 16, 5, 16, 4, 17);
    move_left = 1'b1; tick();
    chk_cells("left", 2, 16, 3, 16, 4, 16, 3, 17);
    move_right = 1'b1; tick();
    chk_cells("right", 3, 16, 4, 16, 5, 16, 4, 17);

    // Soft drop to floor, then lock delay
    repeat (16) begin soft_drop = 1'b1; tick(); end
    chk_cells("floor", 3, 0, 4, 0, 5, 0, 4, 1);
    soft_drop = 1'b1; tick();
    chk("grounded_active", 32'(active), 1);
    chk("grounded_no_lock", 32'(lock_valid), 0);
    repeat (14) begin frame_tick = 1'b1; tick(); end
    chk("lock_14", 32'(lock_valid), 0);
    frame_tick = 1'b1; tick();
    chk("lock_15", 32'(lock_valid), 1);
    chk_cells("lock_cells", 3, 0, 4, 0, 5, 0, 4, 1);
    chk("lock_shape", 32'(shape), 2);
    tick();
    chk("after_lock_pulse", 32'(lock_valid), 0);
    chk("after_lock_active", 32'(active), 0);
    chk("after_lock_shape", 32'(shape), 7);
    chk("after_lock_cells_x", 32'(cells_x), 32'h0000ffff);

    // I piece against the walls
    shape_in = 3'd0; spawn = 1'b1; tick();
    chk_cells("spawn_i", 3, 18, 4, 18, 5, 18, 6, 18);
    repeat (3) begin move_left = 1'b1; tick(); end
    chk_cells("i_left3", 0, 18, 1, 18, 2, 18, 3, 18);
    repeat (2) begin move_left = 1'b1; tick(); end
    chk_cells("i_left5", 0, 18, 1, 18, 2, 18, 3, 18);
    rotate_cw = 1'b1; tick();
    chk("i_rot1_orient", 32'(orientation), 1);
    chk_cells("i_rot1", 1, 19, 1, 18, 1, 17, 1, 16);
    repeat (9) begin move_right = 1'b1; tick(); end
    chk_cells("i_right_wall", 9, 19, 9, 18, 9, 17, 9, 16);
    rotate_cw = 1'b1; tick();
`ifdef PIECE_WALL_KICK_EN
    chk("i_kick_orient", 32'(orientation), 2);
    chk_cells("i_kick", 9, 18, 8, 18, 7, 18, 6, 18);
`else
    chk("i_norot_orient", 32'(orientation), 1);
    chk_cells("i_norot", 9, 19, 9, 18, 9, 17, 9, 16);
`endif

    // Invalid shape, blocked spawn, sticky game over
    reset = 1'b1; #2; reset = 1'b0;
    shape_in = 3'd7; spawn = 1'b1; tick();
    chk("invalid_shape_active", 32'(active), 0);
    board_occ[184] = 1'b1;
    shape_in = 3'd1; spawn = 1'b1; tick();
    chk("over_flag", 32'(game_over), 1);
    chk("over_active", 32'(active), 0);
    chk("over_cells_y", 32'(cells_y), 32'h000fffff);
    board_occ = '0;
    shape_in = 3'd2; spawn = 1'b1; tick();
    chk("over_sticky", 32'(game_over), 1);
    chk("over_spawn_ignored", 32'(active), 0);
    reset = 1'b1; #2;
    chk("over_cleared", 32'(game_over), 0);
    reset = 1'b0;

    // Asynchronous reset mid-fall
    shape_in = 3'd2; spawn = 1'b1; tick();
    chk("respawn_active", 32'(active), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_active", 32'(active), 0);
    chk("async_rst_cells_x", 32'(cells_x), 32'h0000ffff);
    reset = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
